// File: rtl/preg_free_list_pkg.sv
// Shared types and default sizing for the physical scalar register free list.
package preg_free_list_pkg;

  localparam int PSCALAR_NUM    = 64;
  localparam int LSCALAR_NUM    = 32;
  localparam int RENAME_WIDTH   = 2;
  localparam int COMMIT_WIDTH   = 2;
  localparam int FREE_LIST_SIZE = PSCALAR_NUM - LSCALAR_NUM;

  typedef enum logic {
    FL_INIT  = 1'b0,
    FL_READY = 1'b1
  } free_list_state_e;

  typedef logic [$clog2(FREE_LIST_SIZE)-1:0]   free_list_ptr_t;
  typedef logic [$clog2(FREE_LIST_SIZE+1)-1:0] free_list_cnt_t;

endpackage

// File: rtl/preg_free_list_lane_compactor.sv
// Prefix popcount: each lane learns how many lower lanes are valid (its rank),
// plus the total number of valid lanes.
module preg_free_list_lane_compactor #(
  parameter int WIDTH   = 2,
  parameter int RANK_BW = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0]         valid_i,
  output logic [WIDTH*RANK_BW-1:0] rank_o,
  output logic [RANK_BW-1:0]       count_o
);

  logic [RANK_BW-1:0] acc;

  always_comb begin
    acc    = '0;
    rank_o = '0;
    for (int i = 0; i < WIDTH; i++) begin
      rank_o[i*RANK_BW +: RANK_BW] = acc;
      acc = acc + RANK_BW'(valid_i[i]);
    end
    count_o = acc;
  end

endmodule

// File: rtl/preg_free_list.sv
// Circular free list of non-architectural physical registers: rename lanes
// allocate from head, commit lanes return registers at tail.
module preg_free_list
  import preg_free_list_pkg::*;
#(
  parameter int PREG_NUM      = PSCALAR_NUM,
  parameter int LREG_NUM      = LSCALAR_NUM,
  parameter int ALLOC_WIDTH   = RENAME_WIDTH,
  parameter int RELEASE_WIDTH = COMMIT_WIDTH,
  localparam int FL_SIZE      = PREG_NUM - LREG_NUM,
  localparam int PREG_BW      = $clog2(PREG_NUM),
  localparam int PTR_BW       = $clog2(FL_SIZE),
  localparam int CNT_BW       = $clog2(FL_SIZE + 1)
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             reinit,
  input  logic [ALLOC_WIDTH-1:0]           allocReq,
  output logic                             allocGrant,
  output logic [ALLOC_WIDTH*PREG_BW-1:0]   allocRegNum,
  input  logic [RELEASE_WIDTH-1:0]         releaseValid,
  input  logic [RELEASE_WIDTH*PREG_BW-1:0] releaseRegNum,
  output logic                             ready,
  output logic [CNT_BW-1:0]                freeCount,
  output logic                             overflowErr,
  output logic                             state_dbg_o
);

  localparam int A_RBW = $clog2(ALLOC_WIDTH + 1);
  localparam int R_RBW = $clog2(RELEASE_WIDTH + 1);

  free_list_state_e  state_q, state_d;
  logic [PTR_BW-1:0] head_q, head_d, tail_q, tail_d, init_idx_q, init_idx_d;
  logic [CNT_BW-1:0] cnt_q, cnt_d;
  logic              ovf_q, ovf_d;
  logic [PREG_BW-1:0] mem [FL_SIZE];

  logic [ALLOC_WIDTH*A_RBW-1:0]   alloc_rank;
  logic [A_RBW-1:0]               n_req;
  logic [RELEASE_WIDTH*R_RBW-1:0] rel_rank;
  logic [R_RBW-1:0]               n_rel;

  logic               is_ready, init_wr;
  logic [CNT_BW-1:0]  granted, after_alloc, avail, n_rel_c, n_fit;
  logic [RELEASE_WIDTH-1:0] rel_wr;
  logic [PTR_BW-1:0]  rel_idx [RELEASE_WIDTH];

  // Pointer wrap by compare/subtract so FL_SIZE need not be a power of two.
  function automatic logic [PTR_BW-1:0] ptr_add(input logic [PTR_BW-1:0] base,
                                                input logic [PTR_BW:0]   off);
    logic [PTR_BW+1:0] sum;
    sum = {2'b00, base} + {1'b0, off};
    if (sum >= (PTR_BW+2)'(FL_SIZE)) sum = sum - (PTR_BW+2)'(FL_SIZE);
    return sum[PTR_BW-1:0];
  endfunction

  preg_free_list_lane_compactor #(.WIDTH(ALLOC_WIDTH), .RANK_BW(A_RBW)) u_alloc_cmp (
    .valid_i (allocReq),
    .rank_o  (alloc_rank),
    .count_o (n_req)
  );

  preg_free_list_lane_compactor #(.WIDTH(RELEASE_WIDTH), .RANK_BW(R_RBW)) u_rel_cmp (
    .valid_i (releaseValid),
    .rank_o  (rel_rank),
    .count_o (n_rel)
  );

  assign is_ready    = (state_q == FL_READY);
  assign ready       = is_ready;
  assign freeCount   = cnt_q;
  assign overflowErr = ovf_q;
  assign state_dbg_o = state_q;

  // Grant is judged against the registered count, so same-cycle releases
  // only become allocatable on the following cycle.
  always_comb begin
    allocGrant  = is_ready && (n_req != '0) && (cnt_q >= CNT_BW'(n_req));
    allocRegNum = '0;
    for (int l = 0; l < ALLOC_WIDTH; l++) begin
      if (is_ready && allocReq[l])
        allocRegNum[l*PREG_BW +: PREG_BW] =
          mem[ptr_add(head_q, (PTR_BW+1)'(alloc_rank[l*A_RBW +: A_RBW]))];
    end
  end

  always_comb begin
    granted     = allocGrant ? CNT_BW'(n_req) : '0;
    after_alloc = cnt_q - granted;
    avail       = CNT_BW'(FL_SIZE) - after_alloc;
    n_rel_c     = CNT_BW'(n_rel);
    n_fit       = (n_rel_c > avail) ? avail : n_rel_c;
    for (int l = 0; l < RELEASE_WIDTH; l++) begin
      rel_idx[l] = ptr_add(tail_q, (PTR_BW+1)'(rel_rank[l*R_RBW +: R_RBW]));
      rel_wr[l]  = is_ready && !reinit && releaseValid[l] &&
                   (CNT_BW'(rel_rank[l*R_RBW +: R_RBW]) < avail);
    end
  end

  always_comb begin
    state_d    = state_q;
    head_d     = head_q;
    tail_d     = tail_q;
    init_idx_d = init_idx_q;
    cnt_d      = cnt_q;
    ovf_d      = ovf_q;
    init_wr    = 1'b0;
    if (reinit) begin
      state_d    = FL_INIT;
      head_d     = '0;
      tail_d     = '0;
      init_idx_d = '0;
      cnt_d      = '0;
    end else begin
      case (state_q)
        FL_INIT: begin
          init_wr    = 1'b1;
          init_idx_d = ptr_add(init_idx_q, (PTR_BW+1)'(1));
          tail_d     = ptr_add(init_idx_q, (PTR_BW+1)'(1));
          cnt_d      = CNT_BW'(init_idx_q) + CNT_BW'(1);
          if (releaseValid != '0) ovf_d = 1'b1;
          if (init_idx_q == PTR_BW'(FL_SIZE - 1)) state_d = FL_READY;
        end
        FL_READY: begin
          if (allocGrant) head_d = ptr_add(head_q, (PTR_BW+1)'(n_req));
          tail_d = ptr_add(tail_q, (PTR_BW+1)'(n_fit));
          cnt_d  = after_alloc + n_fit;
          if (n_rel_c > avail) ovf_d = 1'b1;
        end
        default: state_d = FL_INIT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= FL_INIT;
      head_q     <= '0;
      tail_q     <= '0;
      init_idx_q <= '0;
      cnt_q      <= '0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      init_idx_q <= init_idx_d;
      cnt_q      <= cnt_d;
      ovf_q      <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (init_wr) mem[init_idx_q] <= PREG_BW'(LREG_NUM) + PREG_BW'(init_idx_q);
    for (int l = 0; l < RELEASE_WIDTH; l++) begin
      if (rel_wr[l]) mem[rel_idx[l]] <= releaseRegNum[l*PREG_BW +: PREG_BW];
    end
  end

endmodule
